// File: rtl/tbus_sim_mem.sv
// -----------------------------------------------------------------------------
// tbus_sim_mem: parametrised Trinity-bus memory responder.
//
// Accepts one read/write request per valid/ready handshake, models a fixed
// access latency, applies a bit-granular write mask and returns the addressed
// word together with a one-cycle completion pulse.
//
// Optional build macro: TBUS_MEM_RAND_DELAY_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1)
//   adds 0..3 extra wait cycles per request, taken from lfsr[1:0] at accept.
//
// Ports:
//   clock                system clock, rising edge
//   reset                synchronous active-high reset
//   tbus_index_valid     request valid
//   tbus_index_ready     responder can accept a request (IDLE, not in reset)
//   tbus_index           byte address; word = index[log2(DATA_WIDTH/8) +: DEPTH_LOG2]
//   tbus_write_data      write data
//   tbus_write_mask      per-bit write enable (1 = write this bit)
//   tbus_operation_type  0 = read, 1 = write, others reserved
//   tbus_read_data       result, valid while tbus_operation_done is high
//   tbus_operation_done  one-cycle completion pulse
//   busy                 a transaction is in flight
// -----------------------------------------------------------------------------
module tbus_sim_mem #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned DEPTH_LOG2   = 12,
  parameter int unsigned LATENCY      = 4,
  parameter int unsigned OPTYPE_WIDTH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tbus_index_valid,
  output logic                    tbus_index_ready,
  input  logic [ADDR_WIDTH-1:0]   tbus_index,
  input  logic [DATA_WIDTH-1:0]   tbus_write_data,
  input  logic [DATA_WIDTH-1:0]   tbus_write_mask,
  input  logic [OPTYPE_WIDTH-1:0] tbus_operation_type,
  output logic [DATA_WIDTH-1:0]   tbus_read_data,
  output logic                    tbus_operation_done,
  output logic                    busy
);

  localparam int unsigned OFFS_W = $clog2(DATA_WIDTH / 8);
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  // Wide enough for LATENCY-1 (max 254) plus up to 3 random extra cycles.
  localparam int unsigned CNT_W  = 9;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [OPTYPE_WIDTH-1:0] OP_READ  = OPTYPE_WIDTH'(0);
  localparam logic [OPTYPE_WIDTH-1:0] OP_WRITE = OPTYPE_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   word_q, word_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   mask_q, mask_d;
  logic [OPTYPE_WIDTH-1:0] type_q, type_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    ready_s;
  logic                    accept_s;
  logic [CNT_W-1:0]        load_s;
  logic [DEPTH_LOG2-1:0]   word_in_s;
  // Byte-offset and alias bits of the index do not select anything.
  logic                    unused_index_s;

  assign word_in_s      = tbus_index[OFFS_W +: DEPTH_LOG2];
  assign unused_index_s = ^tbus_index;

  assign ready_s  = (state_q == ST_IDLE) && !reset;
  assign accept_s = tbus_index_valid && ready_s;

`ifdef TBUS_MEM_RAND_DELAY_EN
  logic [15:0] lfsr_q, lfsr_d;

  // LFSR advances once per accepted request.
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept_s) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign load_s = LAT_LOAD + {{(CNT_W-2){1'b0}}, lfsr_q[1:0]};
`else
  assign load_s = LAT_LOAD;
`endif

  // Next-state, request latching and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    data_d  = data_q;
    mask_d  = mask_q;
    type_d  = type_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          word_d  = word_in_s;
          data_d  = tbus_write_data;
          mask_d  = tbus_write_mask;
          type_d  = tbus_operation_type;
          cnt_d   = load_s;
          // A zero load means a single-cycle latency: skip WAIT entirely.
          state_d = (load_s == 9'd0) ? ST_RESP : ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Leaving on count 1 makes RESP land exactly LATENCY cycles after accept.
        if (cnt_q <= 9'd1) begin
          cnt_d   = 9'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d   = cnt_q - 9'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The word is captured on the edge entering RESP so it is presented in
    // the done cycle; for writes this is the pre-write contents.
    if (state_d == ST_RESP) begin
      case (type_d)
        OP_READ:  rdata_d = mem_q[word_d];
        OP_WRITE: rdata_d = mem_q[word_d];
        default:  rdata_d = '0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 9'd0;
      word_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      type_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      type_q  <= type_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory array (not reset); masked merge against the pre-write word held
  // in rdata_q, committed at the end of the RESP cycle.
  always_ff @(posedge clock) begin
    if (!reset && (state_q == ST_RESP) && (type_q == OP_WRITE)) begin
      mem_q[word_q] <= (rdata_q & ~mask_q) | (data_q & mask_q);
    end
  end

  assign tbus_index_ready    = ready_s;
  assign tbus_read_data      = rdata_q;
  assign tbus_operation_done = (state_q == ST_RESP) && !reset;
  assign busy                = (state_q != ST_IDLE) && !reset;

endmodule
